moving_average_n: RTL and testbench

MOVING_AVERAGE_N -- requirements
Module: moving_average_n

---
 rtl/moving_average_n.sv | 94 +++++++++
 tb/tb_moving_average_n.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/moving_average_n.sv
// Moving average over the last 2**LOG2_DEPTH signed samples. The circular buffer and running sum
// update on each accepted sample, and a registered average follows one cycle later.
module moving_average_n #(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                     system1000,
    input  logic                     system1000_rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     clear,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_full
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam int CNT_W = LOG2_DEPTH + 1;
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);

    logic signed [DATA_W-1:0]     buf_q [DEPTH];
    logic signed [DATA_W-1:0]     buf_d [DEPTH];
    logic        [LOG2_DEPTH-1:0] ptr_q, ptr_d;
    logic signed [SUM_W-1:0]      sum_q, sum_d;
    logic        [CNT_W-1:0]      fill_q, fill_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]     out_data_q, out_data_d;
    logic                         out_full_q, out_full_d;
    logic signed [DATA_W-1:0]     old_sample;

    // A clear zeroes the window first, so a sample arriving in the same cycle starts a new window.
    always_comb begin
        buf_d       = buf_q;
        ptr_d       = ptr_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_full_d  = out_full_q;
        old_sample  = '0;

        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_d[i] = '0;
            end
            ptr_d      = '0;
            sum_d      = '0;
            fill_d     = '0;
            out_full_d = 1'b0;
        end

        if (in_valid) begin
            old_sample    = buf_d[ptr_d];
            sum_d         = sum_d
                          + {{LOG2_DEPTH{in_data[DATA_W-1]}}, in_data}
                          - {{LOG2_DEPTH{old_sample[DATA_W-1]}}, old_sample};
            buf_d[ptr_d]  = in_data;
            ptr_d         = ptr_d + 1'b1;
            if (fill_d != FILL_MAX) begin
                fill_d = fill_d + 1'b1;
            end
            out_full_d  = (fill_d == FILL_MAX);
            out_valid_d = 1'b1;
            out_data_d  = DATA_W'(sum_d >>> LOG2_DEPTH);
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            ptr_q       <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_full_q  <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            ptr_q       <= ptr_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_full_q  <= out_full_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_full  = out_full_q;

endmodule

// File: tb/tb_moving_average_n.sv
// Bench for moving_average_n (DATA_W=8, LOG2_DEPTH=2). It runs directed scenarios and then random
// traffic, checking the DUT against a queue-based window model after every cycle.
module tb_moving_average_n;
    localparam int DW = 8;
    localparam int LG = 2;
    localparam int D  = 1 << LG;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 clear;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 out_full;

    int checks = 0;
    int errors = 0;

    // reference model state
    int                   win[$];
    int                   m_count;
    logic                 m_valid;
    logic signed [DW-1:0] m_data;
    logic                 m_full;

    moving_average_n #(.DATA_W(DW), .LOG2_DEPTH(LG)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .clear          (clear),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_full       (out_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int floor_div(input int s);
        if (s >= 0) return s / D;
        return -((-s + D - 1) / D);
    endfunction

    task automatic model_update(input logic r, input logic c, input logic v, input int d);
        int s;
        if (r) begin
            win.delete();
            m_count = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_full  = 1'b0;
        end else begin
            if (c) begin
                win.delete();
                m_count = 0;
                m_full  = 1'b0;
            end
            if (v) begin
                win.push_back(d);
                if (win.size() > D) void'(win.pop_front());
                if (m_count < D) m_count++;
                s = 0;
                foreach (win[i]) s += win[i];
                m_data  = DW'(floor_div(s));
                m_valid = 1'b1;
                m_full  = (m_count >= D);
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic v, input int d, input string tag);
        rst      = r;
        clear    = c;
        in_valid = v;
        in_data  = DW'(d);
        @(posedge clk);
        model_update(r, c, v, d);
        #1;
        chk({tag, ".valid"}, int'(out_valid), int'(m_valid));
        chk({tag, ".data"},  int'(out_data),  int'(m_data));
        chk({tag, ".full"},  int'(out_full),  int'(m_full));
    endtask

    initial begin
        m_count = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_full  = 1'b0;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;

        // reset state
        step(1, 0, 1, 55, "reset");
        step(1, 1, 1, -7, "reset");
        chk("reset_data_const", int'(out_data), 0);

        // warm-up and wrap
        step(0, 0, 1, 4,  "warm4");
        chk("warm4_const", int'(out_data), 1);
        step(0, 0, 1, 8,  "warm8");
        chk("warm8_const", int'(out_data), 3);
        step(0, 0, 1, 12, "warm12");
        chk("warm12_full_const", int'(out_full), 0);
        step(0, 0, 1, 16, "warm16");
        chk("warm16_const", int'(out_data), 10);
        chk("warm16_full_const", int'(out_full), 1);
        step(0, 0, 1, 20, "wrap20");
        chk("wrap20_const", int'(out_data), 14);
        step(0, 0, 1, 24, "wrap24");
        chk("wrap24_const", int'(out_data), 18);

        // extremes and floor rounding
        step(1, 0, 0, 0, "rst_a");
        for (int i = 0; i < D; i++) step(0, 0, 1, -128, "neg_max");
        chk("neg_max_const", int'(out_data), -128);
        step(1, 0, 0, 0, "rst_b");
        for (int i = 0; i < D; i++) step(0, 0, 1, 127, "pos_max");
        chk("pos_max_const", int'(out_data), 127);
        step(1, 0, 0, 0, "rst_c");
        step(0, 0, 1, -1, "floor_m1");
        chk("floor_m1_const", int'(out_data), -1);

        // gaps hold out_data
        step(1, 0, 0, 0, "rst_d");
        step(0, 0, 1, 8, "gap_first");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 99, "gap_idle");
            chk("gap_hold_const", int'(out_data), 2);
        end
        step(0, 0, 1, 8, "gap_second");
        chk("gap_second_const", int'(out_data), 4);

        // clear with and without a sample
        for (int i = 0; i < D; i++) step(0, 0, 1, 100, "fill100");
        chk("fill100_const", int'(out_data), 100);
        step(0, 1, 1, 40, "clear_accept");
        chk("clear_accept_const", int'(out_data), 10);
        chk("clear_accept_full_const", int'(out_full), 0);
        for (int i = 0; i < D; i++) step(0, 0, 1, 100, "refill100");
        step(0, 1, 0, 0, "clear_only");
        chk("clear_only_valid_const", int'(out_valid), 0);
        step(0, 0, 1, 40, "after_clear");
        chk("after_clear_const", int'(out_data), 10);

        // reset mid-stream
        step(0, 0, 1, 64, "mid64a");
        step(0, 0, 1, 64, "mid64b");
        step(1, 0, 1, 64, "mid_rst");
        step(0, 0, 1, 64, "post_rst");
        chk("post_rst_const", int'(out_data), 16);
        chk("post_rst_full_const", int'(out_full), 0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), int'($signed(8'($urandom))), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
